uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
Serial receiver that consumes the 16x oversampling enable `en_rx` produced by the baud divisor. It synchronises `rxd`, validates the start bit at mid-bit, and samples data LSB-first at bit centres. It checks the stop bit and presents a parallel byte with a ready/read handshake to the CPU-side UART register interface. Frame format is 1 start bit, DATA_BITS data bits, no parity, 1 stop bit.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..8)
OVS, 16, en_rx ticks per bit period; must match the divisor's oversampling ratio

Ports:
clk  input  1  UART clock, all logic on rising edge
rst  input  1  synchronous active-high reset
en_rx  input  1  oversampling tick from divisor, single-cycle pulse
rxd  input  1  asynchronous serial line, idle high
rd_en  input  1  consumer read strobe; acknowledges rx_data
rx_data  output  DATA_BITS  last good received byte
rx_ready  output  1  unread byte available in rx_data
frame_err  output  1  sticky: a stop bit was sampled low
overrun  output  1  sticky: a good frame completed while rx_ready=1 and no rd_en
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous: rst sampled high at clk edge. Reset values: rx_data=0, rx_ready=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, counters=0, sync flops=1. Reset mid-frame aborts the frame with no output update.
- rxd passes through a 2-flop synchroniser (rxd_s). All further logic uses rxd_s only.
- FSM advances only on cycles where en_rx=1, except the rd_en handling, which is evaluated every clk.
- tick_cnt is log2(OVS) bits wide; bit_cnt is 0..DATA_BITS-1.
- IDLE: on en_rx with rxd_s=0, go to START with tick_cnt=0.
- START: tick_cnt increments on each en_rx. When tick_cnt reaches OVS/2-1 (7), re-sample rxd_s:
  - If 0, go to DATA with tick_cnt=0, bit_cnt=0.
  - If 1, the start is a glitch; return to IDLE with no flags.
- DATA: when tick_cnt=OVS-1, shift rxd_s into the MSB of the shift register (right shift, so the first bit received ends up in bit 0) and clear tick_cnt. After the DATA_BITS-th sample, go to STOP.
- STOP: when tick_cnt=OVS-1, sample the stop bit.
  - Sampled 1: rx_data <= shift register, rx_ready <= 1, and overrun <= 1 if rx_ready was 1 and rd_en is 0 this cycle. The new byte overwrites the old one. Go to IDLE at stop-bit centre.
  - Sampled 0: frame_err <= 1; rx_data and rx_ready are unchanged. Go to BREAK.
- BREAK: wait for an en_rx with rxd_s=1, then go to IDLE. This prevents a held-low line from retriggering a start.
- Read handshake:
  - rd_en with rx_ready=1 clears rx_ready, frame_err and overrun on the next edge.
  - rd_en with rx_ready=0 clears only frame_err.
- Simultaneous good-frame completion and rd_en in the same cycle: the new byte is loaded, rx_ready stays 1, overrun is not set, and the previous flags are cleared.
- Latency: rx_ready rises on the clk edge of the en_rx tick at the stop-bit centre, 2 clk synchroniser delay after the line level.
- Sampling point is bit centre ±1 tick. With OVS=16 the tolerated baud mismatch is about ±3%.
- en_rx held permanently high is legal: each clk is then one tick.

Test Plan:
- Bench setup for all scenarios: en_rx pulses every 4 clk, so one bit = 64 clk.
- Send 0xA5 as 8N1 -> rx_data=0xA5, rx_ready=1, frame_err=0 about 9.5 bit times after the start edge; rd_en pulse -> rx_ready=0 next clk.
- Low pulse of 3 ticks (12 clk) on idle line -> FSM returns to IDLE, rx_ready stays 0, busy falls, and a following valid 0x3C is received correctly.
- Send 0x55 with stop bit forced 0 and the line held low for 2 bit times -> frame_err=1, rx_ready=0, rx_data unchanged; no new frame until the line returns high; the next 0x0F is received and frame_err stays 1 until rd_en.
- Send 0x11 then 0x22 back-to-back without rd_en -> rx_data=0x22, rx_ready=1, overrun=1; rd_en clears both flags.
- Repeat the back-to-back case with rd_en asserted on the exact clk the second frame completes -> rx_data=0x22, rx_ready=1, overrun=0.
- Assert rst for 1 clk during data bit 4 of 0xF0 -> all outputs 0 next edge, no byte delivered; the next full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if
//   Register-side view of the UART receiver: the received byte, its
//   ready/read handshake and the sticky status flags.
//   master : the receiver (drives data/flags, samples rd_en)
//   slave  : the CPU-side register block (drives rd_en)
//   Signals:
//     rd_en     read strobe, acknowledges rx_data
//     rx_data   last good received byte
//     rx_ready  unread byte available
//     frame_err sticky stop-bit error
//     overrun   sticky overwrite of an unread byte
//     busy      receiver is not idle
interface uart_rx_core_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rd_en;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    input  rd_en,
    output rx_data,
    output rx_ready,
    output frame_err,
    output overrun,
    output busy
  );

  modport slave (
    output rd_en,
    input  rx_data,
    input  rx_ready,
    input  frame_err,
    input  overrun,
    input  busy
  );
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core
//   Serial receiver driven by a 16x (OVS) oversampling tick. The line is
//   synchronised, the start bit is re-checked at mid-bit, data bits are
//   sampled LSB-first at bit centres and the stop bit is validated before
//   the byte is presented through a ready/read handshake.
//   Frame: 1 start, DATA_BITS data, no parity, 1 stop.
//   Ports:
//     clk    UART clock, rising edge
//     rst    synchronous active-high reset
//     en_rx  oversampling tick, one-cycle pulse
//     rxd    asynchronous serial input, idle high
//     bus    register-side interface (rd_en in; rx_data, rx_ready,
//            frame_err, overrun, busy out)
module uart_rx_core #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned OVS       = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en_rx,
  input  logic           rxd,
  uart_rx_core_if.master bus
);

  localparam int unsigned TW = $clog2(OVS);
  localparam int unsigned BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state, state_n;
  logic [TW-1:0]        tick_cnt, tick_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic [DATA_BITS-1:0] data_q, data_n;
  logic                 ready_q, ready_n;
  logic                 ferr_q, ferr_n;
  logic                 ovr_q, ovr_n;
  logic                 rxd_meta, rxd_s;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      shift_q  <= shift_n;
      data_q   <= data_n;
      ready_q  <= ready_n;
      ferr_q   <= ferr_n;
      ovr_q    <= ovr_n;
    end
  end

  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_q;
    data_n  = data_q;
    ready_n = ready_q;
    ferr_n  = ferr_q;
    ovr_n   = ovr_q;

    // Read handshake is applied first so that a frame completing in the
    // same cycle re-sets rx_ready/frame_err on top of the cleared flags.
    if (bus.rd_en) begin
      ferr_n = 1'b0;
      if (ready_q) begin
        ready_n = 1'b0;
        ovr_n   = 1'b0;
      end
    end

    if (en_rx) begin
      case (state)
        S_IDLE: begin
          if (!rxd_s) begin
            state_n = S_START;
            tick_n  = '0;
          end
        end

        S_START: begin
          if (tick_cnt == TICK_MID) begin
            tick_n = '0;
            bit_n  = '0;
            // Line back high at mid-bit: treat as a glitch.
            state_n = rxd_s ? S_IDLE : S_DATA;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (tick_cnt == TICK_LAST) begin
            tick_n  = '0;
            shift_n = {rxd_s, shift_q[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) begin
              state_n = S_STOP;
            end else begin
              bit_n = bit_cnt + 1'b1;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (tick_cnt == TICK_LAST) begin
            tick_n = '0;
            if (rxd_s) begin
              data_n  = shift_q;
              ready_n = 1'b1;
              if (ready_q && !bus.rd_en) begin
                ovr_n = 1'b1;
              end
              state_n = S_IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = S_BREAK;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end

        // Hold here while the line stays low so a break is not mistaken
        // for a new start bit.
        S_BREAK: begin
          if (rxd_s) begin
            state_n = S_IDLE;
          end
        end

        default: begin
          state_n = S_IDLE;
          tick_n  = '0;
          bit_n   = '0;
        end
      endcase
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_ready  = ready_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
  assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core
//   Directed and randomised frames against a flag-level model of the
//   receiver's register-side behaviour. en_rx pulses every 4 clk, so one
//   bit period is 64 clk.
module tb_uart_rx_core;

  localparam int unsigned BIT_CLK = 64;
  localparam int unsigned FRAME_CLK = 10 * BIT_CLK;
  // Clock index within a frame (counted from the start-bit edge) whose
  // following rising edge is the stop-bit centre tick.
  localparam int unsigned DONE_IDX = 612;

  logic clk;
  logic rst;
  logic en_rx;
  logic rxd;

  uart_rx_core_if #(.DATA_BITS(8)) bus ();

  uart_rx_core #(.DATA_BITS(8), .OVS(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .en_rx (en_rx),
    .rxd   (rxd),
    .bus   (bus)
  );

  int checks;
  int failures;

  // Reference model of the visible registers.
  logic [7:0] m_data;
  logic       m_ready;
  logic       m_ferr;
  logic       m_ovr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int unsigned phase;
    phase = 0;
    en_rx = 1'b0;
    forever begin
      @(negedge clk);
      en_rx = (phase == 0);
      phase = (phase + 1) % 4;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_data"}, 32'(bus.rx_data), 32'(m_data));
    chk({tag, "_ready"}, 32'(bus.rx_ready), 32'(m_ready));
    chk({tag, "_ferr"}, 32'(bus.frame_err), 32'(m_ferr));
    chk({tag, "_ovr"}, 32'(bus.overrun), 32'(m_ovr));
  endtask

  function automatic void model_reset();
    m_data  = '0;
    m_ready = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
  endfunction

  function automatic void model_read();
    if (m_ready) begin
      m_ready = 1'b0;
      m_ovr   = 1'b0;
    end
    m_ferr = 1'b0;
  endfunction

  function automatic void model_frame(input logic [7:0] d, input logic stop_ok, input bit rd);
    logic was_ready;
    was_ready = m_ready;
    if (rd) model_read();
    if (stop_ok) begin
      if (was_ready && !rd) m_ovr = 1'b1;
      m_data  = d;
      m_ready = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endfunction

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic align();
    @(negedge clk);
    #1;
    while (en_rx !== 1'b1) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_read(input string tag);
    @(negedge clk);
    #1;
    bus.rd_en = 1'b1;
    @(negedge clk);
    #1;
    bus.rd_en = 1'b0;
    model_read();
    chk_all(tag);
  endtask

  // Drives one frame. rd_done pulses rd_en on the completion edge;
  // probe checks rx_ready just before and just after that edge;
  // rst_at >= 0 pulses reset for one clk at that frame index.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit rd_done,
                            input bit probe, input int rst_at);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    align();
    for (int c = 0; c < int'(FRAME_CLK); c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      rxd       = bits[c / int'(BIT_CLK)];
      bus.rd_en = rd_done && (c == int'(DONE_IDX));
      if (probe && c == int'(DONE_IDX) - 1) chk("ready_before_stop", 32'(bus.rx_ready), 32'(m_ready));
      if (probe && c == int'(DONE_IDX) + 1) chk("ready_after_stop", 32'(bus.rx_ready), 32'(stop_bit | m_ready));
      if (rst_at >= 0 && c == rst_at) rst = 1'b1;
      if (rst_at >= 0 && c == rst_at + 1) begin
        rst = 1'b0;
        model_reset();
        chk_all("mid_reset");
        chk("mid_reset_busy", 32'(bus.busy), 32'd0);
      end
    end
    if (rst_at < 0) model_frame(d, stop_bit, rd_done);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst       = 1'b1;
    rxd       = 1'b1;
    bus.rd_en = 1'b0;
    model_reset();
    idle(3);
    rst = 1'b0;
    idle(2);
    chk_all("reset");
    chk("reset_busy", 32'(bus.busy), 32'd0);

    // Basic byte with latency probe, then read.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, -1);
    chk_all("a5");
    do_read("a5_read");

    // Short low glitch must be rejected.
    align();
    rxd = 1'b0;
    idle(12);
    rxd = 1'b1;
    chk("glitch_busy_hi", 32'(bus.busy), 32'd1);
    idle(BIT_CLK);
    chk("glitch_busy_lo", 32'(bus.busy), 32'd0);
    chk_all("glitch");
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, -1);
    chk_all("after_glitch");
    do_read("3c_read");

    // Bad stop bit followed by a held-low line.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1);
    idle(2 * BIT_CLK);
    chk_all("break_hold");
    chk("break_busy", 32'(bus.busy), 32'd1);
    rxd = 1'b1;
    idle(BIT_CLK);
    chk("break_exit_busy", 32'(bus.busy), 32'd0);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0, -1);
    chk_all("after_break");
    do_read("0f_read");

    // Overrun on back-to-back frames.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, -1);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, -1);
    chk_all("overrun");
    do_read("overrun_read");

    // Read on the completion edge of the second frame.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, -1);
    send_frame(8'h22, 1'b1, 1'b1, 1'b0, -1);
    chk_all("rd_same_edge");

    // Reset during data bit 4 of 0xF0.
    send_frame(8'hF0, 1'b1, 1'b0, 1'b0, 5 * int'(BIT_CLK) + 30);
    chk_all("after_reset_frame");
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, -1);
    chk_all("after_reset_81");
    do_read("81_read");

    // Randomised frames, stop-bit errors and read timing.
    for (int i = 0; i < 16; i++) begin
      logic [7:0]  d;
      logic        stop_ok;
      int unsigned mode;
      d       = 8'($urandom);
      stop_ok = ($urandom_range(0, 3) != 0);
      mode    = $urandom_range(0, 2);
      send_frame(d, stop_ok, mode == 1, 1'b0, -1);
      chk_all($sformatf("rnd%0d", i));
      if (!stop_ok) begin
        rxd = 1'b1;
        idle(BIT_CLK);
      end
      if (mode == 2) do_read($sformatf("rnd%0d_read", i));
      idle($urandom_range(0, 40));
    end
    idle(BIT_CLK);
    chk("final_busy", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
